// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - I2S serial inputs and stereo frame output handshake.
interface i2s_receiver_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  sck;
  logic                  ws;
  logic                  sd;
  logic [DATA_WIDTH-1:0] out_left;
  logic [DATA_WIDTH-1:0] out_right;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overrun;
  logic                  frame_err;

  modport master (
    input  sck, ws, sd, out_ready,
    output out_left, out_right, out_valid, overrun, frame_err
  );

  modport slave (
    output sck, ws, sd, out_ready,
    input  out_left, out_right, out_valid, overrun, frame_err
  );
endinterface

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S receiver: oversampled sck edge detect, word capture, stereo frame handshake.
module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  i2s_receiver_if.master bus
);
  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAD   = 2'd2;
  localparam logic [CW-1:0] CNT_WORD = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_WIDTH);

  logic                  sck_q, sck_d;
  logic                  ws_last_q, ws_last_d;
  logic                  seen_q, seen_d;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  chan_q, chan_d;
  logic                  have_left_q, have_left_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [DATA_WIDTH-1:0] out_left_q, out_left_d;
  logic [DATA_WIDTH-1:0] out_right_q, out_right_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;

  logic                  rise;
  logic                  ws_edge;
  logic                  start;
  logic                  frame_done;
  logic [DATA_WIDTH:0]   shift_wide;
  logic [DATA_WIDTH-1:0] word_next;

  assign rise       = bus.sck & ~sck_q;
  assign ws_edge    = bus.ws != ws_last_q;
  assign shift_wide = {shift_q, bus.sd};
  assign word_next  = shift_wide[DATA_WIDTH-1:0];

  always_comb begin
    sck_d       = bus.sck;
    ws_last_d   = ws_last_q;
    seen_d      = seen_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    chan_d      = chan_q;
    have_left_d = have_left_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    start       = 1'b0;
    frame_done  = 1'b0;

    if (rise) begin
      ws_last_d = bus.ws;
      seen_d    = 1'b1;
      case (state_q)
        // The first rise after reset only learns ws, so a slot already in progress is never taken as an edge.
        ST_SYNC:  start = seen_q && ws_edge;
        ST_SHIFT: begin
          if (ws_edge) begin
            frame_err_d = 1'b1;
            start       = 1'b1;
          end else begin
            shift_d = word_next;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CNT_WORD) begin
              state_d = ST_PAD;
              if (!chan_q) begin
                left_hold_d = word_next;
                have_left_d = 1'b1;
              end else begin
                have_left_d = 1'b0;
                frame_done  = have_left_q;
              end
            end
          end
        end
        ST_PAD: begin
          if (ws_edge) begin
            start = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end

    // The rise carrying the ws change holds the previous slot's last bit, so it is dropped here.
    if (start) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      chan_d  = bus.ws;
      shift_d = '0;
      if (!bus.ws) have_left_d = 1'b0;
    end

    if (frame_done) begin
      if (!out_valid_q || bus.out_ready) begin
        out_left_d  = left_hold_q;
        out_right_d = word_next;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q       <= 1'b0;
      ws_last_q   <= 1'b0;
      seen_q      <= 1'b0;
      state_q     <= ST_SYNC;
      cnt_q       <= '0;
      chan_q      <= 1'b0;
      have_left_q <= 1'b0;
      shift_q     <= '0;
      left_hold_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sck_q       <= sck_d;
      ws_last_q   <= ws_last_d;
      seen_q      <= seen_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      have_left_q <= have_left_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.out_left  = out_left_q;
  assign bus.out_right = out_right_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
endmodule
